rv_sim_ctrl: RTL
================

Name: rv_sim_ctrl

Overview:
Synthesizable simulation/bring-up controller for the nano_rv32i SoC wrapper.
- Sequences per-domain core resets: a parametrised hold, then a staggered release across N domains.
- Monitors the data-memory store bus for a tohost write and bounds the run with a cycle watchdog.
- Reports pass/fail/timeout and the exit code, so benches and FPGA builds no longer rely on fixed wall-clock delays.

Parameters:
- RST_CYCLES, 5, cycles domain 0 is held in reset after rst_i deasserts (>=1)
- N_DOMAINS, 2, number of independent active-low reset outputs (>=1)
- STAGGER, 2, cycles between releases of successive domains (>=0)
- TIMEOUT_CYCLES, 50, maximum RUN cycles before timeout (>=1)
- ADDR_W, 32, store address width
- DATA_W, 32, store data width
- TOHOST_ADDR, 32'h0000_1000, monitored store address
- HALT_ON_DONE, 1, 1 = reassert all core resets on entering DONE

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- dmem_we_i  in  1  store strobe from core data port
- dmem_addr_i  in  ADDR_W  store address
- dmem_wdata_i  in  DATA_W  store data
- core_rst_n_o  out  N_DOMAINS  active-low per-domain resets
- running_o  out  1  high while in RUN
- done_o  out  1  sticky end-of-test
- pass_o  out  1  sticky pass
- fail_o  out  1  sticky fail (tohost or timeout)
- timeout_o  out  1  sticky watchdog expiry
- exit_code_o  out  DATA_W  tohost code, zero-extended dmem_wdata_i[DATA_W-1:1]
- cycle_cnt_o  out  CNT_W  RUN cycle count, CNT_W = $clog2(TIMEOUT_CYCLES+1)

Behaviour:
- Reset value of every output while rst_i=1: core_rst_n_o all 0, running_o 0, done_o 0, pass_o 0, fail_o 0, timeout_o 0, exit_code_o 0, cycle_cnt_o 0, FSM in HOLD, internal counter 0.
- All outputs are registered.
- Reset is asynchronous: asserting rst_i at any point, including mid-RUN, immediately forces the reset values. No other state survives.
- Edge count: edge 1 is the first rising clk_i edge with rst_i low.

FSM states and transitions:
- HOLD: counter increments each edge. At edge RST_CYCLES, core_rst_n_o[0] goes 1 and the FSM moves to RELEASE. If N_DOMAINS=1 or STAGGER=0, all domains release on that edge and the FSM goes straight to RUN.
- RELEASE: domain k releases at edge RST_CYCLES + k*STAGGER. On the edge the last domain releases, the FSM moves to RUN and running_o goes 1.
- RUN: cycle_cnt_o starts at 0 and increments each edge. Three outcomes on an edge:
  - Qualifying write: DONE, pass_o/fail_o set per the tohost rules below.
  - No qualifying write and cycle_cnt_o reaches TIMEOUT_CYCLES: DONE with timeout_o=1, fail_o=1.
  - Qualifying write and timeout on the same edge: the write wins, timeout_o stays 0.
- DONE: terminal until rst_i. running_o=0, cycle_cnt_o frozen, flags stable. If HALT_ON_DONE=1, core_rst_n_o goes all 0 on the DONE-entry edge; otherwise outputs hold their values.

tohost rules:
- Qualifying write: dmem_we_i=1, dmem_addr_i==TOHOST_ADDR, dmem_wdata_i[0]=1, sampled in RUN.
- dmem_wdata_i==1: pass_o=1, exit_code_o=0.
- Any other odd value: fail_o=1, exit_code_o = dmem_wdata_i>>1.
- Stores with wdata[0]=0 are ignored.
- Stores during HOLD, RELEASE or DONE are ignored.
- Each output is single-driver. pass_o and fail_o are mutually exclusive; done_o = pass_o|fail_o.

Decomposition:
- Shared package rv_sim_pkg holds:
  - FSM state enum: HOLD, RELEASE, RUN, DONE.
  - TOHOST_PASS constant (1).
  - The default TOHOST_ADDR localparam.
- One natural sub-module: rv_rst_stagger (HOLD/RELEASE counter producing core_rst_n_o and a released pulse). rv_sim_ctrl keeps RUN/DONE, the watchdog and the store monitor.

Test Plan (defaults unless noted):
- Release sequence: rst_i high 3 edges, then low → core_rst_n_o[0] rises at edge 5, [1] at edge 7, running_o at edge 7, all outputs 0 before edge 5.
- Pass: in RUN cycle 10 write addr 0x1000 data 0x1 → done_o=1, pass_o=1, fail_o=0, exit_code_o=0, cycle_cnt_o frozen at 11, core_rst_n_o=2'b00 next edge.
- Fail code: write data 0x0000_0007 → fail_o=1, exit_code_o=3; also write data 0x4 first → ignored, still running.
- Timeout: no writes → at RUN edge 50, timeout_o=1, fail_o=1, done_o=1, cycle_cnt_o=50. Same-edge pass write at edge 50 → pass_o=1, timeout_o=0.
- Ignored stores: write 0x1 to 0x1000 during HOLD and to 0x1004 during RUN → no done. HALT_ON_DONE=0 → resets stay high after pass.
- Mid-run reset: assert rst_i asynchronously mid-RUN (between edges) → all outputs return to reset values without waiting for an edge. After release the sequence restarts from HOLD with identical timing.

Source files
------------

// File: rtl/rv_sim_pkg.sv
// Shared definitions for the simulation/bring-up controller.
//   sim_state_t      : controller phase (HOLD, RELEASE, RUN, DONE)
//   TOHOST_PASS      : tohost value that signals a passing test
//   DEF_TOHOST_ADDR  : default monitored store address
package rv_sim_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    DONE
  } sim_state_t;

  localparam int unsigned TOHOST_PASS     = 1;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;

endpackage : rv_sim_pkg

// File: rtl/rv_rst_stagger.sv
// Per-domain reset sequencer.
// Holds every domain in reset for RST_CYCLES edges after rst deasserts, then
// releases domain k at edge RST_CYCLES + k*STAGGER.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   halt       : forces every domain back into reset (level, sampled on clk)
//   core_rst_n : active-low per-domain resets (registered)
//   released   : high during the cycle whose edge releases the last domain
module rv_rst_stagger
  import rv_sim_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 5,
  parameter int unsigned N_DOMAINS  = 2,
  parameter int unsigned STAGGER    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  output logic [N_DOMAINS-1:0] core_rst_n,
  output logic                 released
);

  localparam int unsigned LAST = RST_CYCLES + (N_DOMAINS - 1) * STAGGER;
  localparam int unsigned CW   = $clog2(LAST + 1);

  // RUN here only means "sequence finished"; the counter then freezes.
  sim_state_t    phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  assign cnt_nx   = cnt + 1'b1;
  // Strobe is combinational so the parent can enter RUN on the same edge.
  assign released = (phase != RUN) && (cnt_nx == CW'(LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= HOLD;
      cnt        <= '0;
      core_rst_n <= '0;
    end else begin
      if (phase != RUN) begin
        cnt <= cnt_nx;
        for (int unsigned k = 0; k < N_DOMAINS; k++) begin
          if (cnt_nx == CW'(RST_CYCLES + k * STAGGER)) core_rst_n[k] <= 1'b1;
        end
        if (released)                        phase <= RUN;
        else if (cnt_nx == CW'(RST_CYCLES))  phase <= RELEASE;
      end
      if (halt) core_rst_n <= '0;
    end
  end

endmodule : rv_rst_stagger

// File: rtl/rv_sim_ctrl.sv
// Simulation/bring-up controller for the nano_rv32i SoC wrapper.
// Sequences per-domain core resets, watches the data-memory store bus for a
// tohost write, bounds the run with a cycle watchdog and reports the result.
//   clk_i, rst_i        : clock and asynchronous active-high reset
//   dmem_we_i/addr/wdata: core store bus being monitored
//   core_rst_n_o        : active-low per-domain core resets
//   running_o           : high while the test program runs
//   done_o/pass_o/fail_o/timeout_o : sticky result flags
//   exit_code_o         : tohost code (store data >> 1)
//   cycle_cnt_o         : cycles spent in RUN
module rv_sim_ctrl
  import rv_sim_pkg::*;
#(
  parameter int unsigned        RST_CYCLES     = 5,
  parameter int unsigned        N_DOMAINS      = 2,
  parameter int unsigned        STAGGER        = 2,
  parameter int unsigned        TIMEOUT_CYCLES = 50,
  parameter int unsigned        ADDR_W         = 32,
  parameter int unsigned        DATA_W         = 32,
  parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
  parameter bit                 HALT_ON_DONE   = 1'b1,
  localparam int unsigned       CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 dmem_we_i,
  input  logic [ADDR_W-1:0]    dmem_addr_i,
  input  logic [DATA_W-1:0]    dmem_wdata_i,
  output logic [N_DOMAINS-1:0] core_rst_n_o,
  output logic                 running_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic                 timeout_o,
  output logic [DATA_W-1:0]    exit_code_o,
  output logic [CNT_W-1:0]     cycle_cnt_o
);

  // Pre-RUN sequencing (HOLD/RELEASE) lives in rv_rst_stagger; this FSM
  // waits in HOLD until the last domain is released.
  sim_state_t       state;
  logic             released;
  logic             hit;
  logic             expire;
  logic             halt;
  logic [CNT_W-1:0] cnt_nx;

  assign cnt_nx = cycle_cnt_o + 1'b1;
  assign hit    = dmem_we_i && (dmem_addr_i == TOHOST_ADDR) && dmem_wdata_i[0];
  assign expire = (cnt_nx == CNT_W'(TIMEOUT_CYCLES));
  // Asserted on the DONE-entry edge too, so the cores stop on that edge.
  assign halt   = HALT_ON_DONE &&
                  ((state == DONE) || ((state == RUN) && (hit || expire)));

  rv_rst_stagger #(
    .RST_CYCLES (RST_CYCLES),
    .N_DOMAINS  (N_DOMAINS),
    .STAGGER    (STAGGER)
  ) u_rst_stagger (
    .clk        (clk_i),
    .rst        (rst_i),
    .halt       (halt),
    .core_rst_n (core_rst_n_o),
    .released   (released)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= HOLD;
      running_o   <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      exit_code_o <= '0;
      cycle_cnt_o <= '0;
    end else begin
      case (state)
        HOLD: begin
          if (released) begin
            state     <= RUN;
            running_o <= 1'b1;
          end
        end
        RUN: begin
          cycle_cnt_o <= cnt_nx;
          if (hit) begin
            state       <= DONE;
            running_o   <= 1'b0;
            done_o      <= 1'b1;
            exit_code_o <= dmem_wdata_i >> 1;
            if (dmem_wdata_i == DATA_W'(TOHOST_PASS)) pass_o <= 1'b1;
            else                                      fail_o <= 1'b1;
          end else if (expire) begin
            state     <= DONE;
            running_o <= 1'b0;
            done_o    <= 1'b1;
            fail_o    <= 1'b1;
            timeout_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : rv_sim_ctrl
